// File: rtl/pipe_reg_chain_if.sv
// Ready/valid handshake bundle for one end of pipe_reg_chain.
// The master drives valid and data. The slave drives ready.
interface pipe_reg_chain_if #(
    parameter int WIDTH = 64
);
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: WIDTH-bit, DEPTH-stage elastic register chain with bubble
// collapse, global stall (enable), ready/valid on both ends and occupancy.
// Optional feature macro: PIPE_REG_FLUSH_EN adds a synchronous flush port.

// One register stage: a valid bit plus a data word that only loads valid data.
module pipe_reg_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             clr,
    input  logic             src_v,
    input  logic [WIDTH-1:0] src_d,
    output logic             v,
    output logic [WIDTH-1:0] d
);
    // Clear drops only the valid bit; the data word keeps its last value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v <= 1'b0;
            d <= '0;
        end else if (clr) begin
            v <= 1'b0;
        end else if (load) begin
            v <= src_v;
            if (src_v) d <= src_d;
        end
    end
endmodule

module pipe_reg_chain #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
`ifdef PIPE_REG_FLUSH_EN
    input  logic                         flush,
`endif
    pipe_reg_chain_if.slave              up,
    pipe_reg_chain_if.master             dn,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                        flush_i;
    logic                        go;
    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0][WIDTH-1:0] d;
    logic [DEPTH-1:0]            src_v;
    logic [DEPTH-1:0][WIDTH-1:0] src_d;
    logic [DEPTH-1:0]            rdy;
    logic                        in_fire;
    logic                        out_fire;

`ifdef PIPE_REG_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    assign go = enable & ~flush_i;

    // Stage i is fed by stage i-1. Stage 0 is fed by the upstream port.
    always_comb begin
        src_v    = '0;
        src_d    = '0;
        src_v[0] = up.valid;
        src_d[0] = up.data;
        for (int i = 1; i < DEPTH; i++) begin
            src_v[i] = v[i-1];
            src_d[i] = d[i-1];
        end
    end

    // Stage i can move when downstream is ready or any stage at or after i
    // is empty. This is the unrolled form of rdy[i] = ~v[i] | rdy[i+1].
    always_comb begin
        logic acc;
        rdy = '0;
        acc = dn.ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc    = acc | ~v[i];
            rdy[i] = acc;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        pipe_reg_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (go & rdy[g]),
            .clr     (flush_i),
            .src_v   (src_v[g]),
            .src_d   (src_d[g]),
            .v       (v[g]),
            .d       (d[g])
        );
    end

    // The reset_n term keeps the upstream port closed while reset is held.
    assign up.ready = reset_n & go & rdy[0];
    assign dn.valid = v[DEPTH-1] & go;
    assign dn.data  = d[DEPTH-1];

    assign in_fire  = up.valid & up.ready;
    assign out_fire = dn.valid & dn.ready;

    // Occupancy tracks accepted minus delivered entries. Flush empties it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (flush_i) begin
            count <= '0;
        end else if (in_fire && !out_fire) begin
            count <= count + CW'(1);
        end else if (out_fire && !in_fire) begin
            count <= count - CW'(1);
        end
    end
endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain (WIDTH=8, DEPTH=4).
// The flush scenario is built only when PIPE_REG_FLUSH_EN is defined.
module tb_pipe_reg_chain;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
`ifdef PIPE_REG_FLUSH_EN
    logic       flush;
`endif
    logic [2:0] count;
    int         n_chk = 0;
    int         n_err = 0;

    pipe_reg_chain_if #(.WIDTH(8)) up_if ();
    pipe_reg_chain_if #(.WIDTH(8)) dn_if ();

    pipe_reg_chain #(.WIDTH(8), .DEPTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
`ifdef PIPE_REG_FLUSH_EN
        .flush   (flush),
`endif
        .up      (up_if.slave),
        .dn      (dn_if.master),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic vld, input logic [7:0] dat);
        up_if.valid = vld;
        up_if.data  = dat;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
`ifdef PIPE_REG_FLUSH_EN
        flush   = 1'b0;
`endif
        up_if.valid = 1'b0;
        up_if.data  = '0;
        dn_if.ready = 1'b0;

        // ---- reset state ----
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_oval",  32'(dn_if.valid), 0);
        chk("rst_odata", 32'(dn_if.data), 0);
        chk("rst_irdy",  32'(up_if.ready), 0);
        tick();
        tick();
        reset_n = 1'b1;

        // ---- load 3 entries, then reset mid-stream ----
        push(1'b1, 8'h33); #1; chk("ld_irdy", 32'(up_if.ready), 1); tick();
        push(1'b1, 8'h44); tick();
        push(1'b1, 8'h55); tick();
        push(1'b0, 8'h00); tick();
        chk("ld_count", 32'(count), 3);
        chk("ld_oval",  32'(dn_if.valid), 1);
        chk("ld_odata", 32'(dn_if.data), 32'h33);
        reset_n = 1'b0;
        #1;
        chk("midrst_count", 32'(count), 0);
        chk("midrst_oval",  32'(dn_if.valid), 0);
        chk("midrst_odata", 32'(dn_if.data), 0);
        tick();
        reset_n = 1'b1;

        // ---- first accept after release reaches the tail after 4 edges ----
        dn_if.ready = 1'b1;
        push(1'b1, 8'h11); #1; chk("rel_irdy", 32'(up_if.ready), 1); tick();
        push(1'b0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            #1; chk("rel_lat_oval", 32'(dn_if.valid), 0); tick();
        end
        #1;
        chk("rel_oval",  32'(dn_if.valid), 1);
        chk("rel_odata", 32'(dn_if.data), 32'h11);
        chk("rel_count", 32'(count), 1);
        tick();
        chk("rel_empty", 32'(count), 0);

        // ---- streaming 0x01..0x08 with out_ready=1 ----
        dn_if.ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            int acc, dr;
            push(i < 8, 8'(i + 1));
            #1;
            acc = (i < 8) ? i : 8;
            dr  = (i < 4) ? 0 : ((i - 4 < 8) ? i - 4 : 8);
            chk("str_irdy",  32'(up_if.ready), 1);
            chk("str_oval",  32'(dn_if.valid), 32'(i >= 4 && i < 12));
            if (i >= 4) chk("str_odata", 32'(dn_if.data), 32'(i - 3));
            chk("str_count", 32'(count), 32'(acc - dr));
            tick();
        end
        push(1'b0, 8'h00);

        // ---- backpressure collapse ----
        dn_if.ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push(1'b1, 8'(8'hA0 + i));
            #1;
            chk("bp_irdy", 32'(up_if.ready), 32'(i < 4));
            tick();
        end
        push(1'b0, 8'h00);
        chk("bp_full", 32'(count), 4);
        dn_if.ready = 1'b1;
        #1;
        chk("bp_irdy_rise", 32'(up_if.ready), 1);
        for (int i = 0; i < 4; i++) begin
            chk("bp_oval",  32'(dn_if.valid), 1);
            chk("bp_odata", 32'(dn_if.data), 32'(8'hA0 + i));
            tick();
        end
        chk("bp_empty", 32'(count), 0);

        // ---- stall with two entries held ----
        dn_if.ready = 1'b0;
        push(1'b1, 8'h21); tick();
        push(1'b1, 8'h22); tick();
        push(1'b0, 8'h00); tick();
        tick();
        chk("st_pre_oval",  32'(dn_if.valid), 1);
        chk("st_pre_odata", 32'(dn_if.data), 32'h21);
        enable = 1'b0;
        dn_if.ready = 1'b1;
        push(1'b1, 8'h99);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("st_oval",  32'(dn_if.valid), 0);
            chk("st_irdy",  32'(up_if.ready), 0);
            chk("st_count", 32'(count), 2);
            tick();
        end
        enable = 1'b1;
        push(1'b0, 8'h00);
        #1;
        chk("st_re_oval",  32'(dn_if.valid), 1);
        chk("st_re_odata", 32'(dn_if.data), 32'h21);
        tick();
        chk("st_re_odata2", 32'(dn_if.data), 32'h22);
        tick();
        chk("st_empty_oval", 32'(dn_if.valid), 0);
        chk("st_empty_cnt",  32'(count), 0);

        // ---- full plus simultaneous drain ----
        dn_if.ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(1'b1, 8'(8'hB0 + i));
            tick();
        end
        push(1'b1, 8'hB4);
        #1;
        chk("fd_count", 32'(count), 4);
        chk("fd_irdy_blk", 32'(up_if.ready), 0);
        dn_if.ready = 1'b1;
        #1;
        chk("fd_irdy", 32'(up_if.ready), 1);
        chk("fd_odata0", 32'(dn_if.data), 32'hB0);
        tick();
        push(1'b1, 8'hB5);
        #1;
        chk("fd_count1", 32'(count), 4);
        chk("fd_odata1", 32'(dn_if.data), 32'hB1);
        tick();
        push(1'b0, 8'h00);
        #1;
        chk("fd_count2", 32'(count), 4);
        for (int i = 2; i < 6; i++) begin
            chk("fd_drain", 32'(dn_if.data), 32'(8'hB0 + i));
            tick();
        end
        chk("fd_empty", 32'(count), 0);

`ifdef PIPE_REG_FLUSH_EN
        // ---- flush discards held entries ----
        dn_if.ready = 1'b0;
        push(1'b1, 8'hC1); tick();
        push(1'b1, 8'hC2); tick();
        push(1'b1, 8'hC3); tick();
        flush = 1'b1;
        dn_if.ready = 1'b1;
        push(1'b1, 8'hEE);
        #1;
        chk("fl_irdy", 32'(up_if.ready), 0);
        chk("fl_oval", 32'(dn_if.valid), 0);
        tick();
        flush = 1'b0;
        push(1'b0, 8'h00);
        #1;
        chk("fl_count", 32'(count), 0);
        chk("fl_oval2", 32'(dn_if.valid), 0);
        push(1'b1, 8'h5A); tick();
        push(1'b0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            #1; chk("fl_stale", 32'(dn_if.valid), 0); tick();
        end
        chk("fl_oval3",  32'(dn_if.valid), 1);
        chk("fl_odata",  32'(dn_if.data), 32'h5A);
        chk("fl_count1", 32'(count), 1);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
